// File: rtl/drive_cmd_arbiter.sv
// rtl/drive_cmd_arbiter.sv - motor drive command arbiter between line sensor and remote UART link
//
// Purpose:
//   Chooses the motor drive command from either the autonomous line-sensor
//   path (with anti-chatter hold timing) or remote bytes from uart_rx
//   (with a link watchdog that forces STOP on silence).
//   Optional byte echo towards a UART transmitter: macro CMD_ECHO_EN.
//
// Ports:
//   i_Clock       system clock
//   i_Reset_n     synchronous active-low reset
//   i_Rx_DV       one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte     received UART byte
//   i_Tx_Active   (CMD_ECHO_EN) transmitter busy
//   o_Tx_DV       (CMD_ECHO_EN) one-cycle echo strobe
//   o_Tx_Byte     (CMD_ECHO_EN) echo byte
//   i_Auto_CMD    autonomous drive command
//   i_Auto_Valid  sensor currently sees the line
//   o_DriveCMD    0 left, 1 forward, 2 right, 3 stop
//   o_Mode        0 AUTO, 1 REMOTE, 2 FAILSAFE
//   o_Timeout     one-cycle pulse on watchdog expiry
//   o_Bad_Cnt     saturating count of undecodable bytes
module drive_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CLKS  = 25000000,
  parameter int unsigned MIN_HOLD_CLKS = 50000
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
`ifdef CMD_ECHO_EN
  input  logic       i_Tx_Active,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
`endif
  input  logic [1:0] i_Auto_CMD,
  input  logic       i_Auto_Valid,
  output logic [1:0] o_DriveCMD,
  output logic [1:0] o_Mode,
  output logic       o_Timeout,
  output logic [7:0] o_Bad_Cnt
);

  localparam int unsigned WD_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  // The hold counter must be able to hold MIN_HOLD_CLKS itself (saturation value).
  localparam int unsigned HOLD_W = (MIN_HOLD_CLKS > 0) ? $clog2(MIN_HOLD_CLKS + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CLKS);
  localparam logic [1:0]        CMD_STOP = 2'd3;

  typedef enum logic [1:0] {
    MODE_AUTO     = 2'd0,
    MODE_REMOTE   = 2'd1,
    MODE_FAILSAFE = 2'd2
  } mode_t;

  mode_t             mode_q, mode_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        bad_q, bad_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Byte decode; all flags are qualified by i_Rx_DV.
  logic       is_drive, is_m, is_a, is_bad;
  logic [1:0] drive_val;

  always_comb begin
    is_drive  = 1'b0;
    drive_val = CMD_STOP;
    is_m      = 1'b0;
    is_a      = 1'b0;
    if (i_Rx_DV) begin
      case (i_Rx_Byte)
        8'h30:   begin is_drive = 1'b1; drive_val = 2'd0; end
        8'h31:   begin is_drive = 1'b1; drive_val = 2'd1; end
        8'h32:   begin is_drive = 1'b1; drive_val = 2'd2; end
        8'h53:   begin is_drive = 1'b1; drive_val = CMD_STOP; end
        8'h4D:   is_m = 1'b1;
        8'h41:   is_a = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_bad = i_Rx_DV & ~(is_drive | is_m | is_a);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      mode_q    <= MODE_AUTO;
      cmd_q     <= CMD_STOP;
      timeout_q <= 1'b0;
      bad_q     <= 8'd0;
      wd_q      <= '0;
      hold_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      cmd_q     <= cmd_d;
      timeout_q <= timeout_d;
      bad_q     <= bad_d;
      wd_q      <= wd_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    cmd_d     = cmd_q;
    timeout_d = 1'b0;
    bad_d     = bad_q;
    wd_d      = wd_q;
    hold_d    = hold_q;

    if (is_bad && bad_q != 8'hFF) begin
      bad_d = bad_q + 8'd1;
    end

    case (mode_q)
      MODE_AUTO: begin
        if (is_m) begin
          // Mode change wins over any hold-counter activity this cycle.
          mode_d = MODE_REMOTE;
          cmd_d  = CMD_STOP;
          wd_d   = '0;
        end else if (!i_Auto_Valid) begin
          cmd_d  = CMD_STOP;
          hold_d = '0;
        end else if (i_Auto_CMD != cmd_q && hold_q >= HOLD_MAX) begin
          cmd_d  = i_Auto_CMD;
          hold_d = '0;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      MODE_REMOTE: begin
        if (is_drive) begin
          cmd_d = drive_val;
          wd_d  = '0;
        end else if (is_a) begin
          // Preload the hold so the first autonomous command applies at once.
          mode_d = MODE_AUTO;
          hold_d = HOLD_MAX;
        end else if (is_m) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          // Bad bytes fall through here: they never keep the link alive.
          mode_d    = MODE_FAILSAFE;
          cmd_d     = CMD_STOP;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      MODE_FAILSAFE: begin
        cmd_d = CMD_STOP;
        if (is_m) begin
          mode_d = MODE_REMOTE;
          wd_d   = '0;
        end else if (is_a) begin
          mode_d = MODE_AUTO;
          hold_d = HOLD_MAX;
        end
      end

      default: begin
        mode_d = MODE_AUTO;
        cmd_d  = CMD_STOP;
      end
    endcase
  end

  assign o_DriveCMD = cmd_q;
  assign o_Mode     = mode_q;
  assign o_Timeout  = timeout_q;
  assign o_Bad_Cnt  = bad_q;

`ifdef CMD_ECHO_EN
  // Single-entry pending echo; a newer byte replaces an unsent one.
  logic       pend_q;
  logic [7:0] pend_byte_q;
  logic [7:0] echo_byte;

  assign echo_byte = is_bad ? 8'h3F : i_Rx_Byte;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      pend_q      <= 1'b0;
      pend_byte_q <= 8'd0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= 8'd0;
    end else begin
      o_Tx_DV <= 1'b0;
      if (i_Rx_DV) begin
        if (i_Tx_Active) begin
          pend_q      <= 1'b1;
          pend_byte_q <= echo_byte;
        end else begin
          o_Tx_DV   <= 1'b1;
          o_Tx_Byte <= echo_byte;
          pend_q    <= 1'b0;
        end
      end else if (pend_q && !i_Tx_Active) begin
        o_Tx_DV   <= 1'b1;
        o_Tx_Byte <= pend_byte_q;
        pend_q    <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// tb/tb_drive_cmd_arbiter.sv - scoreboard testbench for drive_cmd_arbiter
module tb_drive_cmd_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [1:0] auto_cmd;
  logic       auto_valid;
  logic [1:0] drive_cmd;
  logic [1:0] mode;
  logic       tmo;
  logic [7:0] bad_cnt;
`ifdef CMD_ECHO_EN
  logic       tx_active;
  logic       tx_dv;
  logic [7:0] tx_byte;
`endif

  always #5 clk = ~clk;

  drive_cmd_arbiter #(
    .TIMEOUT_CLKS (100),
    .MIN_HOLD_CLKS(4)
  ) dut (
    .i_Clock     (clk),
    .i_Reset_n   (resetn),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
`ifdef CMD_ECHO_EN
    .i_Tx_Active (tx_active),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
`endif
    .i_Auto_CMD  (auto_cmd),
    .i_Auto_Valid(auto_valid),
    .o_DriveCMD  (drive_cmd),
    .o_Mode      (mode),
    .o_Timeout   (tmo),
    .o_Bad_Cnt   (bad_cnt)
  );

  typedef struct {
    int         tag;
    logic [1:0] cmd;
    logic [1:0] mode;
    logic       tmo;
    logic [7:0] bad;
    bit         chk_tx;
    logic       tx_dv;
    logic [7:0] tx_byte;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int tag, input logic [1:0] c, input logic [1:0] m,
                           input logic t, input logic [7:0] b, input string nm);
    exp_t e;
    e.tag = tag; e.cmd = c; e.mode = m; e.tmo = t; e.bad = b;
    e.chk_tx = 1'b0; e.tx_dv = 1'b0; e.tx_byte = 8'd0; e.nm = nm;
    q.push_back(e);
  endtask

`ifdef CMD_ECHO_EN
  task automatic expect_tx(input int tag, input logic [1:0] c, input logic [1:0] m,
                           input logic [7:0] b, input logic dv, input logic [7:0] tb,
                           input string nm);
    exp_t e;
    e.tag = tag; e.cmd = c; e.mode = m; e.tmo = 1'b0; e.bad = b;
    e.chk_tx = 1'b1; e.tx_dv = dv; e.tx_byte = tb; e.nm = nm;
    q.push_back(e);
  endtask
`endif

  // Monitor: compares every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.tag < cyc) begin
        check({e.nm, "_missed"}, cyc, e.tag);
      end else begin
        check({e.nm, "_cmd"},  int'(drive_cmd), int'(e.cmd));
        check({e.nm, "_mode"}, int'(mode),      int'(e.mode));
        check({e.nm, "_tmo"},  int'(tmo),       int'(e.tmo));
        check({e.nm, "_bad"},  int'(bad_cnt),   int'(e.bad));
`ifdef CMD_ECHO_EN
        if (e.chk_tx) begin
          check({e.nm, "_txdv"},   int'(tx_dv),   int'(e.tx_dv));
          check({e.nm, "_txbyte"}, int'(tx_byte), int'(e.tx_byte));
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    step();
    rx_dv   = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; rx_dv = 1'b0; rx_byte = 8'd0; auto_cmd = 2'd0; auto_valid = 1'b0;
`ifdef CMD_ECHO_EN
    tx_active = 1'b0;
`endif
    step(); step();

    // 1. reset values, then autonomous follow with a saturated hold counter
    expect_at(cyc + 1, 2'd3, 2'd0, 1'b0, 8'd0, "reset");
    auto_valid = 1'b1; auto_cmd = 2'd3;
    step();
    resetn = 1'b1;
    repeat (6) step();
    auto_cmd = 2'd1;
    expect_at(cyc + 1, 2'd1, 2'd0, 1'b0, 8'd0, "auto_first");
    step();
    auto_valid = 1'b0;
    expect_at(cyc + 1, 2'd3, 2'd0, 1'b0, 8'd0, "auto_lost");
    step();

    // 2. hold timing: change at A, next change no sooner than A+5
    auto_valid = 1'b1; auto_cmd = 2'd3;
    repeat (5) step();
    auto_cmd = 2'd1;
    expect_at(cyc + 1, 2'd1, 2'd0, 1'b0, 8'd0, "hold_a");
    step();
    auto_cmd = 2'd2;
    expect_at(cyc + 1, 2'd1, 2'd0, 1'b0, 8'd0, "hold_b_ign_byte");
    send(8'h32);
    auto_cmd = 2'd0;
    for (int i = 0; i < 3; i++) begin
      expect_at(cyc + 1, 2'd1, 2'd0, 1'b0, 8'd0, "hold_wait");
      step();
    end
    expect_at(cyc + 1, 2'd0, 2'd0, 1'b0, 8'd0, "hold_release");
    step();

    // 3. remote entry, remote drive, return to auto with immediate command
    expect_at(cyc + 1, 2'd3, 2'd1, 1'b0, 8'd0, "rem_enter");
    send(8'h4D);
    expect_at(cyc + 1, 2'd2, 2'd1, 1'b0, 8'd0, "rem_right");
    send(8'h32);
    expect_at(cyc + 1, 2'd2, 2'd0, 1'b0, 8'd0, "rem_to_auto");
    send(8'h41);
    expect_at(cyc + 1, 2'd0, 2'd0, 1'b0, 8'd0, "auto_immediate");
    step();

    // 4. watchdog expiry after 100 silent cycles
    expect_at(cyc + 1, 2'd3, 2'd1, 1'b0, 8'd0, "rem_enter2");
    send(8'h4D);
    repeat (98) step();
    expect_at(cyc + 1, 2'd3, 2'd1, 1'b0, 8'd0, "wd_pre");
    step();
    expect_at(cyc + 1, 2'd3, 2'd2, 1'b1, 8'd0, "wd_expire");
    step();
    expect_at(cyc + 1, 2'd3, 2'd2, 1'b0, 8'd0, "wd_pulse_end");
    step();
    expect_at(cyc + 1, 2'd3, 2'd2, 1'b0, 8'd0, "fs_ign_drive");
    send(8'h31);
    expect_at(cyc + 1, 2'd3, 2'd1, 1'b0, 8'd0, "fs_to_remote");
    send(8'h4D);

    // 5. byte in the expiry cycle wins; bad-byte saturation with a later timeout
    repeat (99) step();
    expect_at(cyc + 1, 2'd1, 2'd1, 1'b0, 8'd0, "expiry_byte_wins");
    send(8'h31);
    for (int k = 1; k <= 300; k++) begin
      case (k)
        1:   expect_at(cyc + 1, 2'd1, 2'd1, 1'b0, 8'd1,   "bad_1");
        99:  expect_at(cyc + 1, 2'd1, 2'd1, 1'b0, 8'd99,  "bad_99");
        100: expect_at(cyc + 1, 2'd3, 2'd2, 1'b1, 8'd100, "bad_no_reload");
        101: expect_at(cyc + 1, 2'd3, 2'd2, 1'b0, 8'd101, "bad_101");
        255: expect_at(cyc + 1, 2'd3, 2'd2, 1'b0, 8'd255, "bad_255");
        256: expect_at(cyc + 1, 2'd3, 2'd2, 1'b0, 8'd255, "bad_sat");
        300: expect_at(cyc + 1, 2'd3, 2'd2, 1'b0, 8'd255, "bad_300");
        default: ;
      endcase
      send(8'h7A);
    end
    resetn = 1'b0;
    rx_dv = 1'b1; rx_byte = 8'h7A;
    expect_at(cyc + 1, 2'd3, 2'd0, 1'b0, 8'd0, "mid_reset");
    step();
    expect_at(cyc + 1, 2'd3, 2'd0, 1'b0, 8'd0, "mid_reset_hold");
    step();
    resetn = 1'b1;
    expect_at(cyc + 1, 2'd3, 2'd0, 1'b0, 8'd1, "post_reset_bad");
    step();
    rx_dv = 1'b0;

`ifdef CMD_ECHO_EN
    // 6. echo held while transmitter is busy; latest byte wins
    auto_valid = 1'b0;
    tx_active  = 1'b1;
    resetn     = 1'b0;
    step(); step();
    resetn = 1'b1;
    expect_tx(cyc + 1, 2'd3, 2'd0, 8'd0, 1'b0, 8'h00, "echo_pend1");
    send(8'h31);
    expect_tx(cyc + 1, 2'd3, 2'd0, 8'd1, 1'b0, 8'h00, "echo_pend2");
    send(8'h7A);
    expect_tx(cyc + 1, 2'd3, 2'd0, 8'd1, 1'b0, 8'h00, "echo_busy");
    step();
    tx_active = 1'b0;
    expect_tx(cyc + 1, 2'd3, 2'd0, 8'd1, 1'b1, 8'h3F, "echo_send");
    step();
    expect_tx(cyc + 1, 2'd3, 2'd0, 8'd1, 1'b0, 8'h3F, "echo_single");
    step();
`endif

    step(); step();
    check("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
